// File: rtl/latch_bus_pkg.sv
// Shared types and helpers for the 16-bit latch bus sequencer.
// One-hot decode and round-robin advance are sized to a fixed maximum and narrowed at the call site.
package latch_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WRITE,
    ST_TURN,
    ST_REJ
  } state_t;

  localparam int IDX_W = 5;
  localparam int OH_W  = 32;

  function automatic logic [OH_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    return OH_W'(1) << idx;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w, input int n);
    return (int'(w) >= n - 1) ? '0 : w + IDX_W'(1);
  endfunction

endpackage

// File: rtl/latch_bus_sequencer_rr_picker.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
module rr_picker
  import latch_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_win,
  output logic               o_vld
);

  // Scan from farthest to nearest so the closest requester to ptr is assigned last.
  always_comb begin
    o_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[idx]) o_win = PTR_W'(idx);
    end
    o_vld = |i_req;
  end

endmodule

// File: rtl/latch_bus_sequencer.sv
// Round-robin sequencer for copies between 16-bit register latches on a shared tri-state bus,
// with a turnaround cycle after every write and 8080-style HOLD/HLDA freeze.
module latch_bus_sequencer
  import latch_bus_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LATCH = 8,
  parameter int SEL_W     = $clog2(NUM_LATCH)
) (
  input  logic                     clk50M_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*SEL_W-1:0] src_sel_i,
  input  logic [NUM_REQ*SEL_W-1:0] dst_sel_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     err_o,
  output logic [NUM_LATCH-1:0]     latch_rd_o,
  output logic [NUM_LATCH-1:0]     latch_wr_o,
  output logic                     busy_o,
  input  logic                     hold_i,
  output logic                     hlda_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_win;
  logic [SEL_W-1:0]     r_dst;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_err;
  logic [NUM_LATCH-1:0] r_rd;
  logic [NUM_LATCH-1:0] r_wr;

  logic [PTR_W-1:0]     w_win;
  logic                 w_vld;
  logic [SEL_W-1:0]     w_src;
  logic [SEL_W-1:0]     w_dst;
  logic                 w_bad;
  logic [NUM_REQ-1:0]   w_win_oh;

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_vld (w_vld)
  );

  assign w_src    = src_sel_i[int'(w_win)*SEL_W +: SEL_W];
  assign w_dst    = dst_sel_i[int'(w_win)*SEL_W +: SEL_W];
  assign w_bad    = (w_src == w_dst) || (int'(w_src) >= NUM_LATCH) || (int'(w_dst) >= NUM_LATCH);
  assign w_win_oh = NUM_REQ'(onehot(IDX_W'(w_win)));

  // Source drive enable is captured at grant; the latched rd vector doubles as the held src index.
  always_ff @(posedge clk50M_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_dst   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!hold_i && w_vld) begin
            r_win <= w_win;
            r_dst <= w_dst;
            r_gnt <= w_win_oh;
            if (w_bad) begin
              r_ack   <= w_win_oh;
              r_err   <= 1'b1;
              r_state <= ST_REJ;
            end else begin
              r_rd    <= NUM_LATCH'(onehot(IDX_W'(w_src)));
              r_state <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          r_wr    <= NUM_LATCH'(onehot(IDX_W'(r_dst)));
          r_ack   <= NUM_REQ'(onehot(IDX_W'(r_win)));
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_rd    <= '0;
          r_wr    <= '0;
          r_state <= ST_TURN;
        end
        ST_TURN: begin
          r_ptr   <= PTR_W'(rr_next(IDX_W'(r_win), NUM_REQ));
          r_state <= ST_IDLE;
        end
        ST_REJ: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_ptr   <= PTR_W'(rr_next(IDX_W'(r_win), NUM_REQ));
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign ack_o      = r_ack;
  assign err_o      = r_err;
  assign latch_rd_o = r_rd;
  assign latch_wr_o = r_wr;
  assign busy_o     = (r_state != ST_IDLE);
  assign hlda_o     = (r_state == ST_IDLE) && hold_i;

endmodule

// File: tb/tb_latch_bus_sequencer.sv
// Bench for latch_bus_sequencer: scoreboard of expected acks, bench-side latch models, scenario tasks.
module tb_latch_bus_sequencer;

  localparam int NR = 4;
  localparam int NL = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*SW-1:0] src_sel = '0, dst_sel = '0;
  logic [NR-1:0] gnt, ack;
  logic          err, busy, hold = 1'b0, hlda;
  logic [NL-1:0] rd, wr;

  logic [NR-1:0] req6 = '0;
  logic [NR*SW-1:0] src6 = '0, dst6 = '0;
  logic [NR-1:0] gnt6, ack6;
  logic          err6, busy6, hlda6;
  logic [5:0]    rd6, wr6;

  always #5 clk = ~clk;

  latch_bus_sequencer #(.NUM_REQ(NR), .NUM_LATCH(NL)) dut (
    .clk50M_i(clk), .rst_i(rst), .req_i(req), .src_sel_i(src_sel), .dst_sel_i(dst_sel),
    .gnt_o(gnt), .ack_o(ack), .err_o(err), .latch_rd_o(rd), .latch_wr_o(wr),
    .busy_o(busy), .hold_i(hold), .hlda_o(hlda)
  );

  latch_bus_sequencer #(.NUM_REQ(NR), .NUM_LATCH(6)) dut6 (
    .clk50M_i(clk), .rst_i(rst), .req_i(req6), .src_sel_i(src6), .dst_sel_i(dst6),
    .gnt_o(gnt6), .ack_o(ack6), .err_o(err6), .latch_rd_o(rd6), .latch_wr_o(wr6),
    .busy_o(busy6), .hold_i(1'b0), .hlda_o(hlda6)
  );

  typedef struct {
    int            id;
    logic [NL-1:0] rd;
    logic [NL-1:0] wr;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   ack_ids[$];
  int   ack_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t e;
  logic [15:0] lat [NL];

  always @(posedge clk) cyc <= cyc + 1;

  // Latch models: the one-hot rd selects the bus value, wr captures it on the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) lat[i] <= 16'h1000 + 16'(i * 16'h111);
      lat[3] <= 16'hBEEF;
    end else if (wr != '0) begin
      for (int i = 0; i < NL; i++)
        if (wr[i]) lat[i] <= lat[$clog2(rd)];
    end
  end

  always @(negedge clk) begin
    if (|ack) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_ack: got ack=%b err=%b, expected no ack", ack, err);
      end else begin
        e = sb.pop_front();
        if ({ack, err, rd, wr} !== {NR'(1 << e.id), e.err, e.rd, e.wr}) begin
          n_bad++;
          $display("FAIL sb_ack: got ack=%b err=%b rd=%h wr=%h, expected ack=%b err=%b rd=%h wr=%h",
                   ack, err, rd, wr, NR'(1 << e.id), e.err, e.rd, e.wr);
        end
      end
      ack_ids.push_back($clog2(ack));
      ack_cyc.push_back(cyc);
    end
    n_cmp++;
    if ($countones(rd) > 1 || $countones(wr) > 1 || $countones(gnt) > 1 ||
        $countones(ack) > 1 || (rd & wr) != '0) begin
      n_bad++;
      $display("FAIL onehot_inv: got gnt=%b ack=%b rd=%h wr=%h, expected at most one bit each and rd&wr=0",
               gnt, ack, rd, wr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int id, input int s, input int d);
    src_sel[id*SW +: SW] = SW'(s);
    dst_sel[id*SW +: SW] = SW'(d);
  endtask

  task automatic push_ok(input int id, input int s, input int d);
    exp_t x;
    x.id = id; x.rd = NL'(1) << s; x.wr = NL'(1) << d; x.err = 1'b0;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req6 = '0; hold = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_cmp++;
    if ({gnt, ack, err, rd, wr, busy, hlda} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b rd=%h wr=%h busy=%b hlda=%b, expected all 0",
               gnt, ack, err, rd, wr, busy, hlda);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    set_sel(0, 3, 5);
    push_ok(0, 3, 5);
    req = 4'b0001;
    tick(1);
    n_cmp++;
    if ({gnt, rd, wr, ack, busy} !== {4'b0001, 8'h08, 8'h00, 4'b0000, 1'b1}) begin
      n_bad++;
      $display("FAIL single_drive: got gnt=%b rd=%h wr=%h ack=%b busy=%b, expected 0001 08 00 0000 1",
               gnt, rd, wr, ack, busy);
    end
    tick(1);
    n_cmp++;
    if ({gnt, rd, wr, ack} !== {4'b0001, 8'h08, 8'h20, 4'b0001}) begin
      n_bad++;
      $display("FAIL single_write: got gnt=%b rd=%h wr=%h ack=%b, expected 0001 08 20 0001", gnt, rd, wr, ack);
    end
    req = '0;
    tick(1);
    n_cmp++;
    if ({gnt, rd, wr, ack, err, busy} !== {4'b0000, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL single_turn: got gnt=%b rd=%h wr=%h ack=%b busy=%b, expected all 0 busy=1",
               gnt, rd, wr, ack, busy);
    end
    tick(1);
    n_cmp++;
    if (lat[5] !== 16'hBEEF || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_copy: got lat5=%h busy=%b, expected BEEF 0", lat[5], busy);
    end
  endtask

  task automatic test_round_robin();
    int seen = 0;
    do_reset();
    for (int i = 0; i < NR; i++) set_sel(i, i, i + 4);
    for (int k = 0; k < 5; k++) push_ok(k % NR, k % NR, (k % NR) + 4);
    ack_ids.delete(); ack_cyc.delete();
    req = 4'b1111;
    for (int k = 0; k < 40 && seen < 5; k++) begin
      tick(1);
      if (ack != '0) seen++;
    end
    req = '0;
    tick(3);
    n_cmp++;
    if (seen != 5 || ack_ids.size() != 5) begin
      n_bad++;
      $display("FAIL rr_count: got %0d acks, expected 5", ack_ids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (ack_ids[k] != k % NR) begin
          n_bad++;
          $display("FAIL rr_order: ack %0d got requester %0d, expected %0d", k, ack_ids[k], k % NR);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (ack_cyc[k+1] - ack_cyc[k] != 4) begin
          n_bad++;
          $display("FAIL rr_spacing: gap %0d got %0d cycles, expected 4", k, ack_cyc[k+1] - ack_cyc[k]);
        end
      end
    end
  endtask

  task automatic test_reject();
    exp_t x;
    set_sel(1, 2, 2);
    x.id = 1; x.rd = '0; x.wr = '0; x.err = 1'b1;
    sb.push_back(x);
    req = 4'b0010;
    tick(1);
    n_cmp++;
    if ({gnt, ack, err, rd, wr} !== {4'b0010, 4'b0010, 1'b1, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL reject_same: got gnt=%b ack=%b err=%b rd=%h wr=%h, expected 0010 0010 1 00 00",
               gnt, ack, err, rd, wr);
    end
    req = '0;
    tick(1);
    n_cmp++;
    if ({gnt, ack, err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reject_done: got gnt=%b ack=%b err=%b busy=%b, expected all 0", gnt, ack, err, busy);
    end
    src6[0 +: SW] = 3'd7;
    dst6[0 +: SW] = 3'd1;
    req6 = 4'b0001;
    tick(1);
    n_cmp++;
    if ({ack6, err6, rd6, wr6} !== {4'b0001, 1'b1, 6'h00, 6'h00}) begin
      n_bad++;
      $display("FAIL reject_range: got ack=%b err=%b rd=%h wr=%h, expected 0001 1 00 00", ack6, err6, rd6, wr6);
    end
    req6 = '0;
    tick(2);
  endtask

  task automatic test_hold();
    set_sel(2, 1, 6);
    hold = 1'b1;
    req = 4'b0100;
    tick(3);
    n_cmp++;
    if ({hlda, gnt, busy} !== {1'b1, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL hold_freeze: got hlda=%b gnt=%b busy=%b, expected 1 0000 0", hlda, gnt, busy);
    end
    push_ok(2, 1, 6);
    hold = 1'b0;
    tick(1);
    n_cmp++;
    if ({gnt, rd, hlda} !== {4'b0100, 8'h02, 1'b0}) begin
      n_bad++;
      $display("FAIL hold_release: got gnt=%b rd=%h hlda=%b, expected 0100 02 0", gnt, rd, hlda);
    end
    hold = 1'b1;
    tick(1);
    n_cmp++;
    if ({ack, wr, hlda} !== {4'b0100, 8'h40, 1'b0}) begin
      n_bad++;
      $display("FAIL hold_midxfer: got ack=%b wr=%h hlda=%b, expected 0100 40 0", ack, wr, hlda);
    end
    req = '0;
    tick(1);
    n_cmp++;
    if (hlda !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_turn: got hlda=%b, expected 0", hlda);
    end
    tick(1);
    n_cmp++;
    if (hlda !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_hlda: got hlda=%b, expected 1", hlda);
    end
    hold = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid();
    set_sel(0, 3, 5);
    push_ok(0, 3, 5);
    req = 4'b0001;
    tick(2);
    rst = 1'b1;
    req = '0;
    tick(1);
    n_cmp++;
    if ({gnt, ack, err, rd, wr, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got gnt=%b ack=%b err=%b rd=%h wr=%h busy=%b, expected all 0",
               gnt, ack, err, rd, wr, busy);
    end
    rst = 1'b0;
    set_sel(1, 4, 0);
    push_ok(1, 4, 0);
    req = 4'b0010;
    tick(1);
    n_cmp++;
    if ({gnt, rd} !== {4'b0010, 8'h10}) begin
      n_bad++;
      $display("FAIL reset_regrant: got gnt=%b rd=%h, expected 0010 10", gnt, rd);
    end
    tick(1);
    req = '0;
    tick(2);
  endtask

  task automatic test_capture();
    logic [15:0] v;
    v = lat[2];
    set_sel(3, 2, 7);
    push_ok(3, 2, 7);
    req = 4'b1000;
    tick(1);
    set_sel(3, 0, 1);
    req = '0;
    tick(1);
    n_cmp++;
    if ({ack, rd, wr} !== {4'b1000, 8'h04, 8'h80}) begin
      n_bad++;
      $display("FAIL capture_sel: got ack=%b rd=%h wr=%h, expected 1000 04 80", ack, rd, wr);
    end
    tick(2);
    n_cmp++;
    if (lat[7] !== v) begin
      n_bad++;
      $display("FAIL capture_copy: got lat7=%h, expected %h", lat[7], v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reject();
    test_hold();
    test_reset_mid();
    test_capture();
    tick(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latch_bus_sequencer.md
Name: latch_bus_sequencer

Overview:
- Arbitrates and sequences transfers on the shared internal 16-bit latch bus between the 16-bit register latches (PC, SP, HL, temp address, etc.).
- Requesters ask for a copy from latch src to latch dst. The block grants round-robin, drives one-hot read enables (tri-state drivers) and write enables, and inserts a turnaround cycle so two latches never drive the bus together.
- Supports an 8080-style HOLD/HLDA freeze.

Parameters:
NUM_REQ, 4, number of requesters
NUM_LATCH, 8, number of 16-bit latches on the bus
SEL_W, $clog2(NUM_LATCH), latch index width (derived; do not override)

Ports:
clk50M_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
req_i  in  NUM_REQ  transfer request per requester; held until ack
src_sel_i  in  NUM_REQ*SEL_W  source latch index, requester i at slice [i*SEL_W +: SEL_W]
dst_sel_i  in  NUM_REQ*SEL_W  destination latch index, same packing
gnt_o  out  NUM_REQ  one-hot, current owner; high from DRIVE through WRITE (or REJ)
ack_o  out  NUM_REQ  one-cycle completion pulse to the owner
err_o  out  1  one-cycle pulse with ack_o when the request was rejected
latch_rd_o  out  NUM_LATCH  one-hot read (bus drive) enables
latch_wr_o  out  NUM_LATCH  one-hot write enables
busy_o  out  1  high in any state other than IDLE
hold_i  in  1  external request to freeze new grants
hlda_o  out  1  high while in IDLE with hold_i high (bus idle and frozen)

Behaviour:
- Reset values (first edge with rst_i high): state IDLE, rr pointer 0, and all outputs 0.
  - This applies mid-transfer too: the next cycle has rd/wr low and no ack is issued.
- States: IDLE, DRIVE, WRITE, TURN, REJ.
- IDLE:
  - If hold_i is high, no grant is made and hlda_o is 1.
  - Otherwise, if any req_i is set, pick the winner: first set bit scanning ptr, ptr+1, … modulo NUM_REQ.
  - Register the winner's src/dst.
  - If src==dst or either index >= NUM_LATCH, go to REJ; else go to DRIVE.
- DRIVE: gnt_o[w]=1 and latch_rd_o[src]=1; the bus settles. Next state is WRITE.
- WRITE: gnt_o[w]=1, latch_rd_o[src]=1, latch_wr_o[dst]=1, ack_o[w]=1. Next state is TURN.
- TURN: all rd/wr/gnt low (bus released); ptr <= (w+1) mod NUM_REQ. Next state is IDLE.
- REJ: gnt_o[w]=1, ack_o[w]=1, err_o=1, no rd/wr; ptr <= (w+1) mod NUM_REQ. Next state is IDLE.
- Latency and throughput:
  - Request sampled in IDLE at cycle 0: DRIVE at cycle 1, write edge and ack at cycle 2, TURN at cycle 3.
  - Next grant is possible at cycle 4, so one transfer per 4 cycles.
  - Rejections take 2 cycles.
- src/dst are captured at grant. Changes to sel inputs or a dropped req_i after grant do not affect the transfer in flight, which always completes.
- The requester must drop req_i the cycle after ack. If it is still high in IDLE, it is a new request arbitrated normally; ptr has already moved past it.
- hold_i rising during a transfer does not abort it. HLDA asserts once IDLE is reached.
- Invariants: at most one bit set in latch_rd_o, latch_wr_o, gnt_o and ack_o; rd and wr never target the same index.

Decomposition:
- Package latch_bus_pkg holds:
  - the state enum (IDLE, DRIVE, WRITE, TURN, REJ)
  - helper functions for one-hot decode and round-robin next-pointer
- Sub-module rr_picker (combinational): inputs req vector and ptr; outputs winner index and valid. Instantiated once.

Test Plan:
1. Reset then single transfer: req_i=4'b0001, src0=3, dst0=5 -> cycle 1 latch_rd_o=8'h08; cycle 2 rd=8'h08, wr=8'h20, ack_o=4'b0001; cycle 3 all zero; with latch models, latch 5 holds latch 3's value (e.g. 16'hBEEF).
2. Round-robin fairness: req_i=4'b1111 held continuously, valid distinct src/dst -> acks in order 0,1,2,3,0, spaced exactly 4 cycles; never two rd bits set.
3. Rejection: src1=dst1=2 -> ack_o[1] and err_o high one cycle after grant, latch_rd_o/latch_wr_o stay 0; NUM_LATCH=6 with src=7 also rejects.
4. HOLD: hold_i=1 with req_i=4'b0100 pending -> hlda_o=1, no grant; release -> grant within 1 cycle. Assert hold_i during DRIVE -> transfer completes, hlda_o rises after TURN.
5. Reset mid-operation: rst_i=1 during WRITE -> next cycle all outputs 0, no ack, ptr=0; a subsequent req_i=4'b0010 is granted normally.
6. Capture check: change src_sel_i/dst_sel_i and drop req_i during DRIVE -> rd/wr still use the values captured at grant, ack still issued.
